pcd_tx_scheduler: RTL and testbench

Command scheduler for the PCD-to-PICC modified-Miller encoder, running in the fc/4 (3.39 MHz) domain. Accepts one reader command at a time from the host, loads and triggers the encoder, waits for its done, opens a response-listen window, retries on timeout, and enforces the inter-command guard time. It reports a status code for each command. It is the only block that drives the encoder's load and trigger inputs.

---
 rtl/pcd_pkg.sv | 44 ++++
 rtl/pcd_tx_scheduler_if.sv | 35 +++
 rtl/pcd_cycle_timer.sv | 31 +++
 rtl/pcd_tx_scheduler.sv | 157 +++++++++++++++
 tb/tb_pcd_tx_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcd_pkg.sv
// rtl/pcd_pkg.sv - shared types, ISO 14443-A timing constants and helpers for the PCD transmit scheduler
package pcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_DONE,
    LISTEN,
    REPORT,
    GUARD
  } sched_state_t;

  typedef enum logic [1:0] {
    STAT_OK        = 2'd0,
    STAT_TIMEOUT   = 2'd1,
    STAT_ENC_FAULT = 2'd2,
    STAT_ABORTED   = 2'd3
  } stat_code_t;

  localparam int unsigned FC_PER_CLK    = 4;
  localparam int unsigned FDT_MIN_FC    = 1172;
  localparam int unsigned GUARD_FC      = 7000;
  localparam int unsigned BITS_PER_BYTE = 9;
  localparam int unsigned GUARD_CLK     = GUARD_FC / FC_PER_CLK;

  localparam logic [6:0] CMD_REQA = 7'h26;
  localparam logic [6:0] CMD_WUPA = 7'h52;

  localparam logic [2:0] MAX_BYTES = 3'd5;

  // A short frame is always a single 7-bit byte; out-of-range counts fall back to a full frame.
  function automatic logic [2:0] clamp_bytes(input logic [2:0] num_bytes, input logic short_frame);
    logic [2:0] result;
    if (short_frame) begin
      result = 3'd1;
    end else if (num_bytes == 3'd0 || num_bytes > MAX_BYTES) begin
      result = MAX_BYTES;
    end else begin
      result = num_bytes;
    end
    return result;
  endfunction

endpackage

// File: rtl/pcd_tx_scheduler_if.sv
// rtl/pcd_tx_scheduler_if.sv - host command, encoder and status signals of the PCD transmit scheduler
interface pcd_tx_scheduler_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [39:0] cmd_data;
  logic [2:0]  cmd_num_bytes;
  logic        cmd_short;
  logic        abort_in;

  logic [39:0] enc_data;
  logic [2:0]  enc_num_bytes;
  logic        enc_short;
  logic        enc_transmit;
  logic        enc_done;

  logic        rx_valid;
  logic        busy;
  logic        stat_valid;
  logic [1:0]  stat_code;
  logic [1:0]  stat_retries;

  modport slave (
    input  cmd_valid, cmd_data, cmd_num_bytes, cmd_short, abort_in, enc_done, rx_valid,
    output cmd_ready, enc_data, enc_num_bytes, enc_short, enc_transmit,
    output busy, stat_valid, stat_code, stat_retries
  );

  modport master (
    output cmd_valid, cmd_data, cmd_num_bytes, cmd_short, abort_in, enc_done, rx_valid,
    input  cmd_ready, enc_data, enc_num_bytes, enc_short, enc_transmit,
    input  busy, stat_valid, stat_code, stat_retries
  );

endinterface

// File: rtl/pcd_cycle_timer.sv
// rtl/pcd_cycle_timer.sv - 16-bit saturating cycle counter with watchdog, listen and guard terminal compares
module pcd_cycle_timer #(
  parameter int unsigned WDOG_LAST   = 255,
  parameter int unsigned LISTEN_LAST = 2047,
  parameter int unsigned GUARD_LAST  = 1749
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic wdog_hit,
  output logic listen_hit,
  output logic guard_hit
);

  logic [15:0] count;

  // Saturates so a long stall can never wrap back onto a terminal value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && count != 16'hFFFF) begin
      count <= count + 16'd1;
    end
  end

  assign wdog_hit   = (count == 16'(WDOG_LAST));
  assign listen_hit = (count == 16'(LISTEN_LAST));
  assign guard_hit  = (count == 16'(GUARD_LAST));

endmodule

// File: rtl/pcd_tx_scheduler.sv
// rtl/pcd_tx_scheduler.sv - PCD command scheduler driving the modified-Miller encoder in the fc/4 domain
// Optional retry-on-timeout path enabled by defining PCD_SCHED_RETRY_EN.
module pcd_tx_scheduler
  import pcd_pkg::*;
#(
  parameter int unsigned LISTEN_CYCLES = 2048,
  parameter int unsigned GUARD_CYCLES  = GUARD_CLK,
  parameter int unsigned WDOG_CYCLES   = 256,
  parameter int unsigned MAX_RETRY     = 2
) (
  input logic               clk_in,
  input logic               rst_in,
  pcd_tx_scheduler_if.slave bus
);

  sched_state_t state, state_next;
  stat_code_t   code_next;
  logic         load_cmd;
  logic         retry_take;
  logic         wdog_hit, listen_hit, guard_hit;
  logic [1:0]   retries;
  logic         retry_pend;
  logic         can_retry;

  pcd_cycle_timer #(
    .WDOG_LAST   (WDOG_CYCLES - 1),
    .LISTEN_LAST (LISTEN_CYCLES - 1),
    .GUARD_LAST  (GUARD_CYCLES - 1)
  ) u_timer (
    .clk        (clk_in),
    .rst        (rst_in),
    .clr        (state_next != state),
    .en         (state != IDLE),
    .wdog_hit   (wdog_hit),
    .listen_hit (listen_hit),
    .guard_hit  (guard_hit)
  );

`ifdef PCD_SCHED_RETRY_EN
  assign can_retry = (32'(retries) < MAX_RETRY);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      retries    <= '0;
      retry_pend <= 1'b0;
    end else begin
      if (load_cmd) begin
        retries <= '0;
      end else if (retry_take) begin
        retries <= retries + 2'd1;
      end
      if (retry_take) begin
        retry_pend <= 1'b1;
      end else if (state_next == LOAD) begin
        retry_pend <= 1'b0;
      end
    end
  end
`else
  logic unused_retry;
  assign can_retry    = 1'b0;
  assign retries      = 2'd0;
  assign retry_pend   = 1'b0;
  assign unused_retry = (^MAX_RETRY) ^ retry_take;
`endif

  // Abort outranks enc_done/rx_valid; rx_valid outranks the listen timeout.
  always_comb begin
    state_next = state;
    code_next  = STAT_OK;
    load_cmd   = 1'b0;
    retry_take = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          load_cmd   = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (bus.abort_in) begin
          code_next  = STAT_ABORTED;
          state_next = REPORT;
        end else begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.abort_in) begin
          code_next  = STAT_ABORTED;
          state_next = REPORT;
        end else if (bus.enc_done) begin
          state_next = LISTEN;
        end else if (wdog_hit) begin
          code_next  = STAT_ENC_FAULT;
          state_next = REPORT;
        end
      end
      LISTEN: begin
        if (bus.abort_in) begin
          code_next  = STAT_ABORTED;
          state_next = REPORT;
        end else if (bus.rx_valid) begin
          code_next  = STAT_OK;
          state_next = REPORT;
        end else if (listen_hit) begin
          if (can_retry) begin
            retry_take = 1'b1;
            state_next = GUARD;
          end else begin
            code_next  = STAT_TIMEOUT;
            state_next = REPORT;
          end
        end
      end
      REPORT: state_next = GUARD;
      GUARD: begin
        if (guard_hit) begin
          state_next = retry_pend ? LOAD : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= IDLE;
      bus.cmd_ready     <= 1'b1;
      bus.busy          <= 1'b0;
      bus.enc_transmit  <= 1'b0;
      bus.stat_valid    <= 1'b0;
      bus.stat_code     <= 2'd0;
      bus.stat_retries  <= 2'd0;
      bus.enc_data      <= '0;
      bus.enc_num_bytes <= '0;
      bus.enc_short     <= 1'b0;
    end else begin
      state            <= state_next;
      bus.cmd_ready    <= (state_next == IDLE);
      bus.busy         <= (state_next != IDLE);
      bus.enc_transmit <= (state_next == LOAD);
      bus.stat_valid   <= (state_next == REPORT);
      if (state_next == REPORT) begin
        bus.stat_code    <= code_next;
        bus.stat_retries <= retries;
      end
      if (load_cmd) begin
        bus.enc_data      <= bus.cmd_data;
        bus.enc_num_bytes <= clamp_bytes(bus.cmd_num_bytes, bus.cmd_short);
        bus.enc_short     <= bus.cmd_short;
      end
    end
  end

endmodule

// File: tb/tb_pcd_tx_scheduler.sv
// tb/tb_pcd_tx_scheduler.sv - scoreboard bench for pcd_tx_scheduler, valid with or without PCD_SCHED_RETRY_EN
module tb_pcd_tx_scheduler;

  localparam int LISTEN = 2048;
  localparam int GUARD  = 1750;
  localparam int WDOG   = 256;
`ifdef PCD_SCHED_RETRY_EN
  localparam int EXP_RETRIES = 2;
`else
  localparam int EXP_RETRIES = 0;
`endif

  typedef struct packed {
    logic [1:0] code;
    logic [1:0] retries;
  } exp_t;

  exp_t exp_q[$];
  time  tx_times[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;
  int   tx_count = 0;
  int   stat_count = 0;

  always #5 clk = ~clk;

  pcd_tx_scheduler_if bus ();

  pcd_tx_scheduler dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always @(negedge clk) begin
    if (bus.enc_transmit) begin
      tx_count++;
      tx_times.push_back($time);
    end
    if (bus.stat_valid) stat_count++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic done, input logic rx, input logic abort);
    bus.enc_done = done;
    bus.rx_valid = rx;
    bus.abort_in = abort;
    @(negedge clk);
    bus.enc_done = 1'b0;
    bus.rx_valid = 1'b0;
    bus.abort_in = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (!bus.cmd_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_stat(input int budget, output int n);
    n = 0;
    while (!bus.stat_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_tx(input int budget, output int n);
    n = 0;
    while (!bus.enc_transmit && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic send_cmd(input logic [39:0] data, input logic [2:0] nb, input logic short_frame);
    int n;
    wait_ready(5000, n);
    bus.cmd_valid     = 1'b1;
    bus.cmd_data      = data;
    bus.cmd_num_bytes = nb;
    bus.cmd_short     = short_frame;
    @(negedge clk);
    bus.cmd_valid     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL reset_ready_busy: ready=%b busy=%b, want ready=1 busy=0", bus.cmd_ready, bus.busy);
    else passed++;
    checks++;
    if ({bus.enc_transmit, bus.stat_valid, bus.stat_code, bus.stat_retries} !== 6'd0)
      $display("FAIL reset_status: tx=%b sv=%b code=%0d retries=%0d, want all 0",
               bus.enc_transmit, bus.stat_valid, bus.stat_code, bus.stat_retries);
    else passed++;
    checks++;
    if (bus.enc_data !== 40'd0 || bus.enc_num_bytes !== 3'd0 || bus.enc_short !== 1'b0)
      $display("FAIL reset_enc_fields: data=%h nb=%0d short=%b, want 0", bus.enc_data, bus.enc_num_bytes, bus.enc_short);
    else passed++;
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_reqa();
    exp_t e;
    int   n;
    int   tx0;
    exp_q.push_back(exp_t'{code: 2'd0, retries: 2'd0});
    tx0 = tx_count;
    send_cmd(40'h26, 3'd1, 1'b1);
    checks++;
    if (bus.enc_transmit !== 1'b1 || bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0)
      $display("FAIL reqa_load: tx=%b busy=%b ready=%b, want 1 1 0", bus.enc_transmit, bus.busy, bus.cmd_ready);
    else passed++;
    checks++;
    if (bus.enc_data !== 40'h26 || bus.enc_short !== 1'b1)
      $display("FAIL reqa_latch: data=%h short=%b, want 26 1", bus.enc_data, bus.enc_short);
    else passed++;
    step(1);
    checks++;
    if (bus.enc_transmit !== 1'b0)
      $display("FAIL reqa_tx_width: tx=%b one cycle after load, want 0", bus.enc_transmit);
    else passed++;
    step(58);
    pulse(1'b1, 1'b0, 1'b0);
    step(299);
    pulse(1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (bus.stat_valid !== 1'b1 || bus.stat_code !== e.code || bus.stat_retries !== e.retries)
      $display("FAIL reqa_status: valid=%b code=%0d retries=%0d, want 1 %0d %0d",
               bus.stat_valid, bus.stat_code, bus.stat_retries, e.code, e.retries);
    else passed++;
    wait_ready(GUARD + 20, n);
    checks++;
    if (n !== GUARD + 1)
      $display("FAIL reqa_guard: cmd_ready after %0d cycles, want %0d", n, GUARD + 1);
    else passed++;
    checks++;
    if (tx_count - tx0 !== 1)
      $display("FAIL reqa_tx_count: %0d pulses, want 1", tx_count - tx0);
    else passed++;
  endtask

  task automatic test_clamp();
    exp_t e;
    int   n;
    for (int k = 0; k < 3; k++) begin
      logic [2:0]  nb_in;
      logic [2:0]  nb_want;
      logic [39:0] data;
      nb_in   = (k == 0) ? 3'd0 : (k == 1) ? 3'd7 : 3'd3;
      nb_want = (k == 2) ? 3'd3 : 3'd5;
      data    = {8'(k + 1), 32'($urandom)};
      exp_q.push_back(exp_t'{code: 2'd3, retries: 2'd0});
      send_cmd(data, nb_in, 1'b0);
      checks++;
      if (bus.enc_num_bytes !== nb_want || bus.enc_data !== data || bus.enc_transmit !== 1'b1)
        $display("FAIL clamp_%0d: nb=%0d data=%h tx=%b, want nb=%0d data=%h tx=1",
                 k, bus.enc_num_bytes, bus.enc_data, bus.enc_transmit, nb_want, data);
      else passed++;
      pulse(1'b0, 1'b0, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (bus.stat_valid !== 1'b1 || bus.stat_code !== e.code || bus.stat_retries !== e.retries)
        $display("FAIL clamp_abort_%0d: valid=%b code=%0d retries=%0d, want 1 %0d %0d",
                 k, bus.stat_valid, bus.stat_code, bus.stat_retries, e.code, e.retries);
      else passed++;
      wait_ready(GUARD + 20, n);
    end
  endtask

  task automatic test_wdog();
    exp_t e;
    int   n;
    exp_q.push_back(exp_t'{code: 2'd2, retries: 2'd0});
    send_cmd(40'hA5, 3'd1, 1'b0);
    wait_stat(WDOG + 40, n);
    checks++;
    if (n !== WDOG + 1)
      $display("FAIL wdog_latency: status after %0d cycles, want %0d", n, WDOG + 1);
    else passed++;
    e = exp_q.pop_front();
    checks++;
    if (bus.stat_valid !== 1'b1 || bus.stat_code !== e.code || bus.stat_retries !== e.retries)
      $display("FAIL wdog_status: valid=%b code=%0d retries=%0d, want 1 %0d %0d",
               bus.stat_valid, bus.stat_code, bus.stat_retries, e.code, e.retries);
    else passed++;
    wait_ready(GUARD + 20, n);
  endtask

  task automatic test_abort_rx();
    exp_t e;
    int   n;
    int   sc;
    exp_q.push_back(exp_t'{code: 2'd3, retries: 2'd0});
    send_cmd(40'h1122, 3'd2, 1'b0);
    step(5);
    pulse(1'b1, 1'b0, 1'b0);
    step(20);
    pulse(1'b0, 1'b1, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (bus.stat_valid !== 1'b1 || bus.stat_code !== e.code || bus.stat_retries !== e.retries)
      $display("FAIL abort_rx_status: valid=%b code=%0d retries=%0d, want 1 %0d %0d",
               bus.stat_valid, bus.stat_code, bus.stat_retries, e.code, e.retries);
    else passed++;
    step(10);
    pulse(1'b0, 1'b0, 1'b1);
    sc = stat_count;
    wait_ready(GUARD + 20, n);
    checks++;
    if (n !== GUARD + 1 - 11)
      $display("FAIL abort_in_guard_timing: cmd_ready after %0d cycles, want %0d", n, GUARD + 1 - 11);
    else passed++;
    checks++;
    if (stat_count !== sc)
      $display("FAIL abort_in_guard_status: %0d extra status pulses, want 0", stat_count - sc);
    else passed++;
  endtask

  task automatic test_rx_last();
    exp_t e;
    int   n;
    exp_q.push_back(exp_t'{code: 2'd0, retries: 2'd0});
    send_cmd(40'h93, 3'd1, 1'b0);
    step(3);
    pulse(1'b1, 1'b0, 1'b0);
    step(LISTEN - 1);
    pulse(1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (bus.stat_valid !== 1'b1 || bus.stat_code !== e.code || bus.stat_retries !== e.retries)
      $display("FAIL rx_last_cycle: valid=%b code=%0d retries=%0d, want 1 %0d %0d",
               bus.stat_valid, bus.stat_code, bus.stat_retries, e.code, e.retries);
    else passed++;
    wait_ready(GUARD + 20, n);
  endtask

  task automatic test_retry();
    exp_t e;
    int   n;
    int   tx0;
    exp_q.push_back(exp_t'{code: 2'd1, retries: 2'(EXP_RETRIES)});
    tx0 = tx_count;
    tx_times.delete();
    send_cmd(40'h52, 3'd1, 1'b1);
    for (int k = 0; k <= EXP_RETRIES; k++) begin
      wait_tx(GUARD + LISTEN + WDOG + 100, n);
      checks++;
      if (bus.enc_transmit !== 1'b1 || bus.enc_data !== 40'h52)
        $display("FAIL retry_tx_%0d: tx=%b data=%h, want 1 52", k, bus.enc_transmit, bus.enc_data);
      else passed++;
      step(10);
      pulse(1'b1, 1'b0, 1'b0);
    end
    wait_stat(LISTEN + 40, n);
    checks++;
    if (n !== LISTEN)
      $display("FAIL retry_timeout_latency: status after %0d cycles, want %0d", n, LISTEN);
    else passed++;
    e = exp_q.pop_front();
    checks++;
    if (bus.stat_valid !== 1'b1 || bus.stat_code !== e.code || bus.stat_retries !== e.retries)
      $display("FAIL retry_status: valid=%b code=%0d retries=%0d, want 1 %0d %0d",
               bus.stat_valid, bus.stat_code, bus.stat_retries, e.code, e.retries);
    else passed++;
    wait_ready(GUARD + 20, n);
    checks++;
    if (tx_count - tx0 !== EXP_RETRIES + 1)
      $display("FAIL retry_tx_count: %0d pulses, want %0d", tx_count - tx0, EXP_RETRIES + 1);
    else passed++;
    for (int k = 1; k < tx_times.size(); k++) begin
      checks++;
      if ((tx_times[k] - tx_times[k-1]) / 10 < GUARD)
        $display("FAIL retry_spacing_%0d: %0d cycles, want >= %0d", k, (tx_times[k] - tx_times[k-1]) / 10, GUARD);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int sc;
    int tc;
    send_cmd(40'h7788, 3'd2, 1'b0);
    step(3);
    pulse(1'b1, 1'b0, 1'b0);
    step(100);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.stat_valid !== 1'b0 || bus.enc_transmit !== 1'b0)
      $display("FAIL reset_mid: busy=%b ready=%b sv=%b tx=%b, want 0 1 0 0",
               bus.busy, bus.cmd_ready, bus.stat_valid, bus.enc_transmit);
    else passed++;
    rst = 1'b0;
    sc = stat_count;
    tc = tx_count;
    step(30);
    checks++;
    if (stat_count !== sc || tx_count !== tc || bus.cmd_ready !== 1'b1)
      $display("FAIL reset_mid_quiet: status=%0d tx=%0d ready=%b after reset, want 0 0 1",
               stat_count - sc, tx_count - tc, bus.cmd_ready);
    else passed++;
  endtask

  initial begin
    bus.cmd_valid     = 1'b0;
    bus.cmd_data      = '0;
    bus.cmd_num_bytes = '0;
    bus.cmd_short     = 1'b0;
    bus.abort_in      = 1'b0;
    bus.enc_done      = 1'b0;
    bus.rx_valid      = 1'b0;
    test_reset();
    test_reqa();
    test_clamp();
    test_wdog();
    test_abort_rx();
    test_rx_last();
    test_retry();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: run exceeded 90000 cycles, %0d/%0d checks passed so far", passed, checks);
    $fatal(1);
  end

endmodule
